// File: rtl/spi_membus_master.sv
// SPI mode-0 initiator for the 16-bit memory-bus frame {write, addr[6:0], data[7:0]}.
// One command in flight; the byte clocked in on MISO during the second frame byte is returned.
module spi_membus_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int GAP      = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_write_i,
    input  logic [6:0] cmd_addr_i,
    input  logic [7:0] cmd_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       busy_o,
    output logic       spi_ssel_o,
    output logic       spi_sck_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i
);

    localparam int HW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TMAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > GAP) ? CS_SETUP : GAP)
                                               : ((CS_HOLD > GAP) ? CS_HOLD : GAP);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [HW-1:0] HALF_LD  = HW'(CLK_DIV - 1);
    localparam logic [TW-1:0] SETUP_LD = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(CS_HOLD - 1);
    localparam logic [TW-1:0] GAP_LD   = TW'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t        r_state, w_state;
    logic [HW-1:0] r_half,  w_half;
    logic [TW-1:0] r_tmr,   w_tmr;
    logic [3:0]    r_bit,   w_bit;
    logic [14:0]   r_shift, w_shift;
    logic [7:0]    r_rx,    w_rx;
    logic [7:0]    r_rdata, w_rdata;
    logic          r_rsp_valid, w_rsp_valid;
    logic          r_ready, w_ready;
    logic          r_ssel,  w_ssel;
    logic          r_sck,   w_sck;
    logic          r_mosi,  w_mosi;

    always_comb begin
        w_state     = r_state;
        w_half      = r_half;
        w_tmr       = r_tmr;
        w_bit       = r_bit;
        w_shift     = r_shift;
        w_rx        = r_rx;
        w_rdata     = r_rdata;
        w_rsp_valid = 1'b0;
        w_ready     = r_ready;
        w_ssel      = r_ssel;
        w_sck       = r_sck;
        w_mosi      = r_mosi;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    // Frame bit 15 goes straight to MOSI; the remaining 15 bits wait in the shifter.
                    w_state = S_SETUP;
                    w_shift = {cmd_addr_i, (cmd_write_i ? cmd_wdata_i : 8'h00)};
                    w_mosi  = cmd_write_i;
                    w_tmr   = SETUP_LD;
                    w_ready = 1'b0;
                    w_ssel  = 1'b0;
                end
            end
            S_SETUP: begin
                if (r_tmr == '0) begin
                    w_state = S_SHIFT;
                    w_half  = HALF_LD;
                    w_bit   = 4'd15;
                end else begin
                    w_tmr = r_tmr - 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_half != '0) begin
                    w_half = r_half - 1'b1;
                end else begin
                    w_half = HALF_LD;
                    if (!r_sck) begin
                        w_sck = 1'b1;
                        w_rx  = {r_rx[6:0], spi_miso_i};
                    end else begin
                        w_sck = 1'b0;
                        if (r_bit == 4'd0) begin
                            w_state = S_HOLD;
                            w_tmr   = HOLD_LD;
                            w_mosi  = 1'b0;
                        end else begin
                            w_bit   = r_bit - 4'd1;
                            w_mosi  = r_shift[14];
                            w_shift = {r_shift[13:0], 1'b0};
                        end
                    end
                end
            end
            S_HOLD: begin
                if (r_tmr == '0) begin
                    // The last 8 MISO samples are exactly the second frame byte.
                    w_state     = S_GAP;
                    w_tmr       = GAP_LD;
                    w_ssel      = 1'b1;
                    w_rsp_valid = 1'b1;
                    w_rdata     = r_rx;
                end else begin
                    w_tmr = r_tmr - 1'b1;
                end
            end
            S_GAP: begin
                if (r_tmr == '0) begin
                    w_state = S_IDLE;
                    w_ready = 1'b1;
                end else begin
                    w_tmr = r_tmr - 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_ready = 1'b1;
                w_ssel  = 1'b1;
                w_sck   = 1'b0;
                w_mosi  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_half      <= '0;
            r_tmr       <= '0;
            r_bit       <= 4'd0;
            r_rdata     <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_ready     <= 1'b1;
            r_ssel      <= 1'b1;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_half      <= w_half;
            r_tmr       <= w_tmr;
            r_bit       <= w_bit;
            r_rdata     <= w_rdata;
            r_rsp_valid <= w_rsp_valid;
            r_ready     <= w_ready;
            r_ssel      <= w_ssel;
            r_sck       <= w_sck;
            r_mosi      <= w_mosi;
        end
    end

    // Shift data is always reloaded before use, so it carries no reset.
    always_ff @(posedge clk_i) begin
        r_shift <= w_shift;
        r_rx    <= w_rx;
    end

    assign cmd_ready_o = r_ready;
    assign busy_o      = ~r_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rdata;
    assign spi_ssel_o  = r_ssel;
    assign spi_sck_o   = r_sck;
    assign spi_mosi_o  = r_mosi;

endmodule
